// File: rtl/morse_decoder.sv
// Morse receive decoder: measures mark/space run lengths on each TickEn sample
// and turns up to MAX_ELEMS dot/dash elements into a 3-bit letter code (A..H).
module morse_decoder #(
   parameter int DASH_LEN   = 3,
   parameter int LETTER_GAP = 3,
   parameter int MAX_ELEMS  = 4
) (
   input  logic       ClockIn,
   input  logic       Resetn,
   input  logic       TickEn,
   input  logic       DotDashIn,
   output logic [2:0] Letter,
   output logic       LetterValid,
   output logic       Error,
   output logic       Busy
);

   typedef enum logic [1:0] {IDLE, MARK, SPACE, CLOSE} state_t;

   state_t     state, state_nxt;
   logic [2:0] markcnt, markcnt_nxt;
   logic [2:0] spacecnt, spacecnt_nxt;
   logic [3:0] elems, elems_nxt;
   logic [2:0] elemcnt, elemcnt_nxt;
   logic       err, err_nxt;
   logic [2:0] letter_nxt;
   logic       valid_nxt, error_nxt;

   logic       dec_ok;
   logic [2:0] dec_code;
   logic       is_dot, is_dash;
   logic [2:0] space_inc;

   // Pattern is held right-aligned: first element ends up in bit elemcnt-1.
   always_comb begin
      dec_ok   = 1'b1;
      dec_code = 3'd0;
      case ({elemcnt, elems})
         {3'd2, 4'b0001}: dec_code = 3'd0;
         {3'd4, 4'b1000}: dec_code = 3'd1;
         {3'd4, 4'b1010}: dec_code = 3'd2;
         {3'd3, 4'b0100}: dec_code = 3'd3;
         {3'd1, 4'b0000}: dec_code = 3'd4;
         {3'd4, 4'b0010}: dec_code = 3'd5;
         {3'd3, 4'b0110}: dec_code = 3'd6;
         {3'd4, 4'b0000}: dec_code = 3'd7;
         default:         dec_ok   = 1'b0;
      endcase
   end

   assign is_dot    = (markcnt == 3'd1);
   assign is_dash   = (markcnt == 3'(DASH_LEN));
   assign space_inc = (spacecnt == 3'd7) ? spacecnt : spacecnt + 3'd1;

   always_comb begin
      state_nxt    = state;
      markcnt_nxt  = markcnt;
      spacecnt_nxt = spacecnt;
      elems_nxt    = elems;
      elemcnt_nxt  = elemcnt;
      err_nxt      = err;
      letter_nxt   = Letter;
      valid_nxt    = 1'b0;
      error_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (TickEn && DotDashIn) begin
               state_nxt   = MARK;
               markcnt_nxt = 3'd1;
               elems_nxt   = 4'd0;
               elemcnt_nxt = 3'd0;
               err_nxt     = 1'b0;
            end
         end
         MARK: begin
            if (TickEn) begin
               if (DotDashIn) begin
                  if (markcnt != 3'd7) markcnt_nxt = markcnt + 3'd1;
               end else begin
                  if (!(is_dot || is_dash)) err_nxt = 1'b1;
                  if (elemcnt == 3'(MAX_ELEMS)) begin
                     err_nxt = 1'b1;
                  end else begin
                     elems_nxt   = {elems[2:0], is_dash};
                     elemcnt_nxt = elemcnt + 3'd1;
                  end
                  spacecnt_nxt = 3'd1;
                  state_nxt    = SPACE;
               end
            end
         end
         SPACE: begin
            if (TickEn) begin
               if (DotDashIn) begin
                  // A space longer than one element gap but short of a letter gap
                  if (spacecnt != 3'd1) err_nxt = 1'b1;
                  markcnt_nxt = 3'd1;
                  state_nxt   = MARK;
               end else begin
                  spacecnt_nxt = space_inc;
                  if (space_inc == 3'(LETTER_GAP)) begin
                     // Decode on the gap-completing tick so strobes land in CLOSE
                     state_nxt = CLOSE;
                     if (err || !dec_ok) begin
                        error_nxt = 1'b1;
                     end else begin
                        valid_nxt  = 1'b1;
                        letter_nxt = dec_code;
                     end
                  end
               end
            end
         end
         CLOSE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ClockIn or negedge Resetn) begin
      if (!Resetn) begin
         state       <= IDLE;
         markcnt     <= 3'd0;
         spacecnt    <= 3'd0;
         elems       <= 4'd0;
         elemcnt     <= 3'd0;
         err         <= 1'b0;
         Letter      <= 3'd0;
         LetterValid <= 1'b0;
         Error       <= 1'b0;
      end else begin
         state       <= state_nxt;
         markcnt     <= markcnt_nxt;
         spacecnt    <= spacecnt_nxt;
         elems       <= elems_nxt;
         elemcnt     <= elemcnt_nxt;
         err         <= err_nxt;
         Letter      <= letter_nxt;
         LetterValid <= valid_nxt;
         Error       <= error_nxt;
      end
   end

   assign Busy = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed cases plus random letter streams checked
// against a run-length / dot-dash-string reference model.
module tb_morse_decoder;

   logic       ClockIn = 1'b0;
   logic       Resetn;
   logic       TickEn;
   logic       DotDashIn;
   logic [2:0] Letter;
   logic       LetterValid;
   logic       Error;
   logic       Busy;

   int total = 0;
   int bad   = 0;

   morse_decoder dut (
      .ClockIn    (ClockIn),
      .Resetn     (Resetn),
      .TickEn     (TickEn),
      .DotDashIn  (DotDashIn),
      .Letter     (Letter),
      .LetterValid(LetterValid),
      .Error      (Error),
      .Busy       (Busy)
   );

   always #5 ClockIn = ~ClockIn;

   // reference model state
   bit    m_active;
   bit    m_in_mark;
   int    m_mark_len, m_space_len, m_nmarks;
   bit    m_err;
   string m_pat;
   logic [2:0] m_letter;
   bit    e_valid, e_error, e_busy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lookup(input string p);
      case (p)
         ".-":   return 0;
         "-...": return 1;
         "-.-.": return 2;
         "-..":  return 3;
         ".":    return 4;
         "..-.": return 5;
         "--.":  return 6;
         "....": return 7;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_active = 0; m_in_mark = 0; m_err = 0; m_pat = "";
      m_mark_len = 0; m_space_len = 0; m_nmarks = 0; m_letter = 3'd0;
   endtask

   task automatic model_step(input bit s);
      int code;
      e_valid = 0; e_error = 0;
      if (!m_active) begin
         if (s) begin
            m_active = 1; m_in_mark = 1; m_mark_len = 1;
            m_pat = ""; m_err = 0; m_nmarks = 0;
         end
      end else if (m_in_mark) begin
         if (s) m_mark_len++;
         else begin
            m_nmarks++;
            if (m_mark_len == 1)      m_pat = {m_pat, "."};
            else if (m_mark_len == 3) m_pat = {m_pat, "-"};
            else                      m_err = 1;
            m_in_mark = 0; m_space_len = 1;
         end
      end else begin
         if (s) begin
            if (m_space_len == 2) m_err = 1;
            m_in_mark = 1; m_mark_len = 1;
         end else begin
            m_space_len++;
            if (m_space_len == 3) begin
               code = lookup(m_pat);
               if (m_err || m_nmarks > 4 || code < 0) e_error = 1;
               else begin
                  e_valid = 1; m_letter = 3'(code);
               end
               m_active = 0;
            end
         end
      end
      e_busy = m_active || e_valid || e_error;
   endtask

   int n_valid, n_error;

   task automatic tick(input bit s);
      @(negedge ClockIn);
      TickEn = 1'b1; DotDashIn = s;
      model_step(s);
      @(negedge ClockIn);
      TickEn = 1'b0;
      chk("valid", 32'(LetterValid), 32'(e_valid));
      chk("error", 32'(Error), 32'(e_error));
      chk("letter", 32'(Letter), 32'(m_letter));
      chk("busy", 32'(Busy), 32'(e_busy));
      if (LetterValid) n_valid++;
      if (Error) n_error++;
      @(negedge ClockIn);
      chk("strobe_clr", 32'({LetterValid, Error}), 32'd0);
      chk("busy_after", 32'(Busy), 32'(m_active));
      @(negedge ClockIn);
   endtask

   task automatic ticks(input string seq);
      for (int i = 0; i < seq.len(); i++) tick(seq[i] == "1");
   endtask

   task automatic emit_run(input bit v, input int n);
      for (int i = 0; i < n; i++) tick(v);
   endtask

   initial begin
      Resetn = 1'b0; TickEn = 1'b0; DotDashIn = 1'b0;
      model_reset();
      n_valid = 0; n_error = 0;
      #12;
      chk("rst_outs", 32'({Letter, LetterValid, Error, Busy}), 32'd0);
      Resetn = 1'b1;

      // 1: A
      ticks("10111000");
      chk("t1_letter", 32'(Letter), 32'd0);
      // 2: H then E, two strobes
      n_valid = 0;
      ticks("1010101000");
      chk("t2_h", 32'(Letter), 32'd7);
      ticks("1000");
      chk("t2_e", 32'(Letter), 32'd4);
      chk("t2_cnt", 32'(n_valid), 32'd2);
      // 3: 2-tick mark
      n_error = 0; n_valid = 0;
      ticks("11000");
      chk("t3_err", 32'(n_error), 32'd1);
      chk("t3_novalid", 32'(n_valid), 32'd0);
      chk("t3_letter", 32'(Letter), 32'd4);
      // 4: five dots
      n_error = 0;
      ticks("101010101000");
      chk("t4_err", 32'(n_error), 32'd1);
      chk("t4_busy", 32'(Busy), 32'd0);
      // saturating mark run
      n_error = 0;
      emit_run(1'b1, 9); emit_run(1'b0, 3);
      chk("sat_err", 32'(n_error), 32'd1);
      // 5: reset mid-letter
      ticks("101");
      @(posedge ClockIn); #2;
      Resetn = 1'b0;
      #1;
      chk("t5_async", 32'({Letter, LetterValid, Error, Busy}), 32'd0);
      model_reset();
      @(negedge ClockIn); @(negedge ClockIn);
      Resetn = 1'b1;
      ticks("1110101000");
      chk("t5_d", 32'(Letter), 32'd3);
      // 6: no ticks, line toggling mid-letter
      ticks("10");
      for (int i = 0; i < 20; i++) begin
         @(negedge ClockIn);
         DotDashIn = ~DotDashIn;
         chk("t6_hold", 32'({Letter, LetterValid, Error, Busy}),
             32'({m_letter, 1'b0, 1'b0, m_active}));
      end
      ticks("00");
      chk("t6_e", 32'(Letter), 32'd4);

      // random letter streams
      for (int l = 0; l < 60; l++) begin
         int ne;
         ne = $urandom_range(1, 6);
         for (int e = 0; e < ne; e++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0)      emit_run(1'b1, $urandom_range(0, 1) ? 2 : $urandom_range(4, 9));
            else if (r < 10) emit_run(1'b1, 1);
            else             emit_run(1'b1, 3);
            if (e != ne - 1) emit_run(1'b0, ($urandom_range(0, 15) == 0) ? 2 : 1);
         end
         emit_run(1'b0, $urandom_range(3, 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
